code_encode: RTL and testbench
==============================

CODE_ENCODE -- requirements
Module: code_encode

Interface
REQ-001 Parameter BIT_DIV, default 100, glb_100M cycles per serial bit (legal range 2..1023).
REQ-002 Parameter GAP_BITS, default 8, minimum idle bit periods after each frame (legal range 1..255).
REQ-003 glb_100M  input  1  system clock, 100 MHz; all logic rising-edge on this single clock.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  frame request, single-cycle pulse.
REQ-006 work_mode  input  8  work mode byte.
REQ-007 wave_code  input  8  waveform code byte.
REQ-008 fre_code  input  8  frequency code byte.
REQ-009 pri_code  input  8  PRI code byte.
REQ-010 pulse_mode  input  8  pulse mode byte.
REQ-011 FPRI  output  1  frame sync, high during the first bit period of each frame.
REQ-012 code  output  1  serial control-word line, MSB first.
REQ-013 busy  output  1  high from frame start through end of gap.
REQ-014 done  output  1  one-cycle pulse at frame completion.

Function
REQ-015 Frame SHALL be 64 bits, in byte order: 8'hAA, 8'h55, work_mode, wave_code, fre_code, pri_code, pulse_mode, checksum.
REQ-016 Checksum SHALL be the bitwise XOR of bytes 3..7 (work_mode through pulse_mode).
REQ-017 Each byte SHALL be sent MSB first; the frame SHALL be the 64-bit concatenation shifted out from bit 63.
REQ-018 States: IDLE, SHIFT, GAP; reset state IDLE.
REQ-019 IDLE: start=1 at a rising edge SHALL capture all five field inputs and the computed checksum into a 64-bit shift register and move to SHIFT.
REQ-020 Latency: code SHALL present frame bit 63 and FPRI/busy SHALL be 1 in the cycle immediately after the edge that sampled start.
REQ-021 SHIFT: each bit SHALL be held for exactly BIT_DIV cycles; the frame SHALL occupy exactly 64*BIT_DIV cycles.
REQ-022 FPRI SHALL be 1 for exactly the first BIT_DIV cycles of the frame, otherwise 0.
REQ-023 After the last bit period, the FSM SHALL enter GAP; done SHALL be 1 for exactly the first GAP cycle.
REQ-024 GAP: code=0, FPRI=0, busy=1 for exactly GAP_BITS*BIT_DIV cycles, then IDLE with busy=0.
REQ-025 start in SHIFT or GAP SHALL be ignored, with no queuing; field inputs changing during SHIFT/GAP SHALL NOT alter the frame in flight.
REQ-026 start asserted on the first IDLE cycle after GAP SHALL be accepted (back-to-back frames separated by exactly GAP_BITS bit periods).
REQ-027 start held high for multiple cycles SHALL produce one frame per acceptance, i.e. a new frame after each GAP.
REQ-028 In IDLE: code=0, FPRI=0, busy=0, done=0.
REQ-029 code, FPRI, busy and done SHALL be driven directly from flip-flops (no combinational output paths).
REQ-030 Bit-divider counter SHALL be wide enough for BIT_DIV-1; bit counter SHALL be 6 bits with terminal count 63; neither counter SHALL wrap inside a frame.

Reset
REQ-031 rst_n=0 SHALL immediately force code=0, FPRI=0, busy=0, done=0, state IDLE, and counters and shift register to 0, regardless of clock.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no done pulse; after rst_n deasserts, the first start SHALL produce a complete new frame.
REQ-033 The first rising edge after rst_n deassertion SHALL be able to accept start.

Verification (BIT_DIV=4, GAP_BITS=2 unless stated)
REQ-034 work_mode=8'h01, wave_code=8'h02, fre_code=8'h04, pri_code=8'h08, pulse_mode=8'h10, one start pulse -> code serialises AA 55 01 02 04 08 10 1F over 256 cycles, FPRI high for cycles 1..4, done at cycle 257, busy low at cycle 265.
REQ-035 All fields 8'hFF -> checksum 8'hFF; all fields 8'h00 -> checksum 8'h00; frame header AA 55 intact in both.
REQ-036 start pulsed at cycles 10, 100 and 262 after the first accepted start -> all ignored, single frame output; start on first IDLE cycle -> second frame begins next cycle.
REQ-037 Inputs changed to 8'h5A at cycle 50 of a frame -> transmitted bytes match values captured at start.
REQ-038 rst_n pulsed low at cycle 120 of a frame -> outputs 0 asynchronously, no done; next start -> full correct frame.
REQ-039 BIT_DIV=100, GAP_BITS=8 -> frame 6400 cycles, FPRI width 100 cycles, busy width 7200 cycles.

Source files
------------

// File: rtl/code_encode.sv
// Serial control-word encoder: frames five field bytes plus header and checksum
// into a 64-bit word, shifts it out MSB first at BIT_DIV clocks per bit, then
// holds an idle gap of GAP_BITS bit periods before accepting the next request.
module code_encode #(
    parameter int unsigned BIT_DIV  = 100,
    parameter int unsigned GAP_BITS = 8
) (
    input  logic       glb_100M,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] work_mode,
    input  logic [7:0] wave_code,
    input  logic [7:0] fre_code,
    input  logic [7:0] pri_code,
    input  logic [7:0] pulse_mode,
    output logic       FPRI,
    output logic       code,
    output logic       busy,
    output logic       done
);

    localparam int unsigned GAP_CYC = GAP_BITS * BIT_DIV;
    localparam int unsigned DIV_W   = $clog2(BIT_DIV);
    localparam int unsigned GAP_W   = $clog2(GAP_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [5:0]         bit_q, bit_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [63:0]        sh_q, sh_d;
    logic               fpri_q, fpri_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [7:0]         checksum_c;
    logic [63:0]        frame_c;

    // Frame image assembled from the live field inputs; captured only on acceptance
    assign checksum_c = work_mode ^ wave_code ^ fre_code ^ pri_code ^ pulse_mode;
    assign frame_c    = {8'hAA, 8'h55, work_mode, wave_code, fre_code,
                         pri_code, pulse_mode, checksum_c};

    // State and datapath registers with asynchronous clear
    always_ff @(posedge glb_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            sh_q    <= '0;
            fpri_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            sh_q    <= sh_d;
            fpri_q  <= fpri_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; the shift register is zero outside SHIFT so code idles low
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        sh_d    = sh_q;
        fpri_d  = fpri_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    sh_d    = frame_c;
                    div_d   = '0;
                    bit_d   = '0;
                    fpri_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                if (div_q == DIV_W'(BIT_DIV - 1)) begin
                    div_d  = '0;
                    fpri_d = 1'b0;
                    if (bit_q == 6'd63) begin
                        state_d = GAP;
                        sh_d    = '0;
                        bit_d   = '0;
                        gap_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 6'd1;
                        sh_d  = {sh_q[62:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d = IDLE;
                    gap_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign code = sh_q[63];
    assign FPRI = fpri_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_code_encode.sv
// Bench for code_encode: directed and random frames compared cycle by cycle
// against a frame/timing model, plus a width check at the default parameters.
module tb_code_encode;

    localparam int BD        = 4;
    localparam int GB        = 2;
    localparam int FRAME_CYC = 64 * BD;
    localparam int GAP_CYC   = GB * BD;
    localparam int FULL      = FRAME_CYC + GAP_CYC + 1;

    logic       clk = 1'b0;
    logic       rst_n, start, start2;
    logic [7:0] wm, wc, fc, pc, pm;
    logic       fpri, code, busy, done;
    logic       fpri2, code2, busy2, done2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    code_encode #(.BIT_DIV(BD), .GAP_BITS(GB)) dut (
        .glb_100M(clk), .rst_n(rst_n), .start(start),
        .work_mode(wm), .wave_code(wc), .fre_code(fc), .pri_code(pc), .pulse_mode(pm),
        .FPRI(fpri), .code(code), .busy(busy), .done(done)
    );

    code_encode #(.BIT_DIV(100), .GAP_BITS(8)) dut2 (
        .glb_100M(clk), .rst_n(rst_n), .start(start2),
        .work_mode(wm), .wave_code(wc), .fre_code(fc), .pri_code(pc), .pulse_mode(pm),
        .FPRI(fpri2), .code(code2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_code"}, 32'(code), 32'd0);
        chk({tag, "_fpri"}, 32'(fpri), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Reference frame: header bytes, five fields, XOR of the fields, packed byte by byte
    function automatic logic [63:0] model_frame(input logic [7:0] a, b, c, d, e);
        logic [7:0]  by [8];
        logic [63:0] f;
        by = '{8'hAA, 8'h55, a, b, c, d, e, a ^ b ^ c ^ d ^ e};
        f  = '0;
        for (int i = 0; i < 8; i++) f = (f << 8) | 64'(by[i]);
        return f;
    endfunction

    task automatic randomize_fields();
        wm = 8'($urandom); wc = 8'($urandom); fc = 8'($urandom);
        pc = 8'($urandom); pm = 8'($urandom);
    endtask

    // Request a frame at the current negedge, then check `total` cycles of output.
    // Injection cycles (-1 = none): extra start pulses, field change, reset.
    task automatic run_frame(input logic [63:0] exp_frame, input int total,
                             input int p0, input int p1, input int p2,
                             input int chg_at, input int rst_at);
        logic ec, ef, eb, ed;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int t = 1; t <= total; t++) begin
            if (t <= FRAME_CYC) begin
                ec = exp_frame[63 - (t - 1) / BD];
                ef = (t <= BD);
                eb = 1'b1;
                ed = 1'b0;
            end else if (t <= FRAME_CYC + GAP_CYC) begin
                ec = 1'b0; ef = 1'b0; eb = 1'b1;
                ed = (t == FRAME_CYC + 1);
            end else begin
                ec = 1'b0; ef = 1'b0; eb = 1'b0; ed = 1'b0;
            end
            chk("code", 32'(code), 32'(ec));
            chk("fpri", 32'(fpri), 32'(ef));
            chk("busy", 32'(busy), 32'(eb));
            chk("done", 32'(done), 32'(ed));
            start = (t == p0 || t == p1 || t == p2);
            if (t == chg_at) begin
                wm = 8'h5A; wc = 8'h5A; fc = 8'h5A; pc = 8'h5A; pm = 8'h5A;
            end
            if (t == rst_at) begin
                start = 1'b0;
                rst_n = 1'b0;
                #1;
                check_idle("async_rst");
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check_idle("in_rst");
                end
                break;
            end
            if (t < total) @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int busy_cnt, fpri_cnt, done_at;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        wm = '0; wc = '0; fc = '0; pc = '0; pm = '0;
        #1;
        check_idle("reset");
        @(negedge clk);
        @(negedge clk);
        check_idle("reset_clk");
        rst_n = 1'b1;

        // Directed known frame; also exercises acceptance on the first edge after reset
        wm = 8'h01; wc = 8'h02; fc = 8'h04; pc = 8'h08; pm = 8'h10;
        run_frame(64'hAA55_0102_0408_101F, FULL, -1, -1, -1, -1, -1);

        // All-ones and all-zeros fields
        wm = 8'hFF; wc = 8'hFF; fc = 8'hFF; pc = 8'hFF; pm = 8'hFF;
        run_frame(64'hAA55_FFFF_FFFF_FFFF, FULL, -1, -1, -1, -1, -1);
        wm = 8'h00; wc = 8'h00; fc = 8'h00; pc = 8'h00; pm = 8'h00;
        run_frame(64'hAA55_0000_0000_0000, FULL, -1, -1, -1, -1, -1);

        // Starts during SHIFT/GAP ignored, then back-to-back on the first idle cycle
        randomize_fields();
        run_frame(model_frame(wm, wc, fc, pc, pm), FULL, 10, 100, 262, -1, -1);
        randomize_fields();
        run_frame(model_frame(wm, wc, fc, pc, pm), FULL, -1, -1, -1, -1, -1);

        // Field inputs changing mid-frame must not disturb the captured frame
        randomize_fields();
        run_frame(model_frame(wm, wc, fc, pc, pm), FULL, -1, -1, -1, 50, -1);

        // Reset mid-frame aborts it; the first start afterwards gives a full frame
        randomize_fields();
        run_frame(model_frame(wm, wc, fc, pc, pm), FULL, -1, -1, -1, -1, 120);
        rst_n = 1'b1;
        randomize_fields();
        run_frame(model_frame(wm, wc, fc, pc, pm), FULL, -1, -1, -1, -1, -1);

        // Random back-to-back frames
        for (int i = 0; i < 4; i++) begin
            randomize_fields();
            run_frame(model_frame(wm, wc, fc, pc, pm), FULL, -1, -1, -1, -1, -1);
        end

        // Default-parameter instance: frame, FPRI and busy widths
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        busy_cnt = 0; fpri_cnt = 0; done_at = -1;
        for (int t = 1; t <= 8000; t++) begin
            if (!busy2) break;
            busy_cnt++;
            if (fpri2) fpri_cnt++;
            if (done2 && done_at < 0) done_at = t;
            @(negedge clk);
        end
        chk("busy2_width", 32'(busy_cnt), 32'd7200);
        chk("fpri2_width", 32'(fpri_cnt), 32'd100);
        chk("done2_cycle", 32'(done_at), 32'd6401);
        chk("code2_idle", 32'(code2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
